// File: rtl/break_away_pkg.sv
// Shared types and 12 MHz timing defaults for the break-away PMOD input logic.
package break_away_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } rep_state_e;

  localparam int DEBOUNCE_10MS      = 120000;
  localparam int REPEAT_DELAY_500MS = 6000000;
  localparam int REPEAT_RATE_100MS  = 1200000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_synchronizer.sv
// Multi-flop synchronizer for an asynchronous pin; resets to a chosen idle level.
module input_synchronizer #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    else            sync_q <= sync_d;
  end

  assign o_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Debounced button level with press/release pulses and hold-to-repeat pulses.
module button_conditioner
  import break_away_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int DEBOUNCE_CYCLES     = DEBOUNCE_10MS,
  parameter bit ACTIVE_HIGH         = 1'b1,
  parameter bit REPEAT_ENABLE       = 1'b1,
  parameter int REPEAT_DELAY_CYCLES = REPEAT_DELAY_500MS,
  parameter int REPEAT_RATE_CYCLES  = REPEAT_RATE_100MS
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_button,
  output logic o_state,
  output logic o_press,
  output logic o_release,
  output logic o_repeat,
  output logic o_event
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_W = $clog2(max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) + 1);
  // Terminal values are one short: the accepting cycle is the Nth count.
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] DLY_LAST  = TM_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TM_W-1:0] RATE_LAST = TM_W'(REPEAT_RATE_CYCLES - 1);
  localparam logic RAW_IDLE = ACTIVE_HIGH ? 1'b0 : 1'b1;

  logic raw_sync, synced;

  input_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (RAW_IDLE)
  ) u_sync (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_async   (i_button),
    .o_sync    (raw_sync)
  );

  assign synced = ACTIVE_HIGH ? raw_sync : ~raw_sync;

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            state_q, state_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            repeat_q, repeat_d;
  logic            event_q, event_d;
  rep_state_e      fsm_q, fsm_d;
  logic [TM_W-1:0] timer_q, timer_d;

  always_comb begin
    db_cnt_d  = '0;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (synced != state_q) begin
      if (db_cnt_q == DB_LAST) begin
        state_d   = synced;
        press_d   = synced;
        release_d = ~synced;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Release wins over a coinciding repeat tick so the two never share a cycle.
  always_comb begin
    fsm_d    = fsm_q;
    timer_d  = timer_q;
    repeat_d = 1'b0;
    if (release_d) begin
      fsm_d   = RELEASED;
      timer_d = '0;
    end else if (press_d) begin
      fsm_d   = HELD_DELAY;
      timer_d = '0;
    end else begin
      case (fsm_q)
        HELD_DELAY: begin
          if (REPEAT_ENABLE) begin
            if (timer_q == DLY_LAST) begin
              repeat_d = 1'b1;
              timer_d  = '0;
              fsm_d    = HELD_REPEAT;
            end else begin
              timer_d = timer_q + TM_W'(1);
            end
          end
        end
        HELD_REPEAT: begin
          if (timer_q == RATE_LAST) begin
            repeat_d = 1'b1;
            timer_d  = '0;
          end else begin
            timer_d = timer_q + TM_W'(1);
          end
        end
        default: timer_d = '0;
      endcase
    end
    event_d = press_d | repeat_d;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      db_cnt_q  <= '0;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      event_q   <= 1'b0;
      fsm_q     <= RELEASED;
      timer_q   <= '0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      event_q   <= event_d;
      fsm_q     <= fsm_d;
      timer_q   <= timer_d;
    end
  end

  assign o_state   = state_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_repeat  = repeat_q;
  assign o_event   = event_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: cycle table, corner sequences, random run vs reference model.
module tb_button_conditioner;

  localparam int SYNC = 2, DEB = 4, DLY = 10, RATE = 3;

  logic clk = 1'b0, rst_n = 1'b0, btn = 1'b0, btn_lo = 1'b1;
  logic st0, pr0, rl0, rp0, ev0;
  logic st1, pr1, rl1, rp1, ev1;
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_HIGH(1'b1), .REPEAT_ENABLE(1'b1),
    .REPEAT_DELAY_CYCLES(DLY), .REPEAT_RATE_CYCLES(RATE)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_button(btn),
    .o_state(st0), .o_press(pr0), .o_release(rl0), .o_repeat(rp0), .o_event(ev0)
  );

  button_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_HIGH(1'b0), .REPEAT_ENABLE(1'b0),
    .REPEAT_DELAY_CYCLES(DLY), .REPEAT_RATE_CYCLES(RATE)
  ) dut_lo (
    .i_clock(clk), .i_reset_n(rst_n), .i_button(btn_lo),
    .o_state(st1), .o_press(pr1), .o_release(rl1), .o_repeat(rp1), .o_event(ev1)
  );

  // Reference: sample delay line, run-length acceptance, repeat times from press time.
  int   m_hist [2][SYNC];
  int   m_run [2], m_pt [2];
  logic m_st [2], m_pr [2], m_rl [2], m_rp [2], m_ev [2], m_held [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < SYNC; k++) m_hist[i][k] = 0;
      m_run[i] = 0; m_pt[i] = 0;
      m_st[i] = 0; m_pr[i] = 0; m_rl[i] = 0; m_rp[i] = 0; m_ev[i] = 0; m_held[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int lvl, sy, dt;
      lvl = (i == 0) ? int'(btn) : int'(!btn_lo);
      sy  = m_hist[i][0];
      for (int k = 0; k < SYNC - 1; k++) m_hist[i][k] = m_hist[i][k+1];
      m_hist[i][SYNC-1] = lvl;
      m_pr[i] = 0; m_rl[i] = 0; m_rp[i] = 0;
      if (sy != int'(m_st[i])) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_run[i] = 0;
          m_st[i]  = (sy == 1);
          m_pr[i]  = (sy == 1);
          m_rl[i]  = (sy == 0);
        end
      end else begin
        m_run[i] = 0;
      end
      if (m_pr[i]) begin m_held[i] = 1; m_pt[i] = cyc; end
      if (m_rl[i]) m_held[i] = 0;
      dt = cyc - m_pt[i];
      if (i == 0 && m_held[i] && !m_pr[i] && dt >= DLY && (dt - DLY) % RATE == 0) m_rp[i] = 1;
      m_ev[i] = m_pr[i] | m_rp[i];
    end
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("m_state0", st0, m_st[0]);  chk("m_press0", pr0, m_pr[0]);
    chk("m_rel0", rl0, m_rl[0]);    chk("m_rep0", rp0, m_rp[0]);  chk("m_evt0", ev0, m_ev[0]);
    chk("m_state1", st1, m_st[1]);  chk("m_press1", pr1, m_pr[1]);
    chk("m_rel1", rl1, m_rl[1]);    chk("m_rep1", rp1, m_rp[1]);  chk("m_evt1", ev1, m_ev[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
    check_all();
  endtask

  typedef struct {
    logic btn, st, pr, rl, rp, ev;
  } vec_t;
  localparam int NV = 46;
  vec_t tbl [NV];

  initial begin
    int cnt, idx_a, idx_b;
    // Cycle c = c-th edge after reset release; held through 36, released after.
    for (int c = 1; c <= NV; c++) begin
      tbl[c-1].btn = (c <= 36);
      tbl[c-1].st  = (c >= 6 && c < 42);
      tbl[c-1].pr  = (c == 6);
      tbl[c-1].rl  = (c == 42);
      tbl[c-1].rp  = (c >= 16 && c < 42 && (c - 16) % 3 == 0);
      tbl[c-1].ev  = tbl[c-1].pr | tbl[c-1].rp;
    end

    model_reset();
    btn = 1'b1;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_outputs0", {st0, pr0, rl0, rp0, ev0}, 0);
      chk("rst_outputs1", {st1, pr1, rl1, rp1, ev1}, 0);
    end
    rst_n = 1'b1;

    for (int c = 0; c < NV; c++) begin
      btn = tbl[c].btn;
      tick();
      chk("tbl_state", st0, tbl[c].st);   chk("tbl_press", pr0, tbl[c].pr);
      chk("tbl_release", rl0, tbl[c].rl); chk("tbl_repeat", rp0, tbl[c].rp);
      chk("tbl_event", ev0, tbl[c].ev);
    end

    // Glitch shorter than the debounce window.
    cnt = 0;
    for (int k = 0; k < 13; k++) begin
      btn = (k < 3);
      tick();
      cnt += int'(st0) + int'(pr0) + int'(rl0) + int'(rp0);
    end
    chk("glitch_activity", cnt, 0);

    // Bouncy release; a repeat tick lands on the release cycle and must be dropped.
    btn = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk("bounce_pre_state", st0, 1);
    cnt = 0; idx_a = -1; idx_b = 0;
    for (int j = 0; j < 20; j++) begin
      btn = (j < 10) ? 1'((j / 2) % 2) : 1'b0;
      tick();
      if (rl0) begin cnt++; idx_a = j; end
      if (j >= 13 && rp0) idx_b++;
    end
    chk("bounce_rel_count", cnt, 1);
    chk("bounce_rel_cycle", idx_a, 13);
    chk("bounce_rep_after", idx_b, 0);

    // Reset while o_repeat is high in HELD_REPEAT.
    for (int k = 0; k < 4; k++) tick();
    btn = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40 && cnt < 2; k++) begin
      tick();
      if (rp0) cnt++;
    end
    chk("mid_rep_reached", cnt, 2);
    chk("mid_rep_high", rp0, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out0", {st0, pr0, rl0, rp0, ev0}, 0);
    chk("async_rst_out1", {st1, pr1, rl1, rp1, ev1}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    idx_a = -1; idx_b = -1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (pr0 && idx_a < 0) idx_a = c;
      if (rp0 && idx_b < 0) idx_b = c;
    end
    chk("post_rst_press", idx_a, 6);
    chk("post_rst_repeat", idx_b, 16);
    btn = 1'b0;
    for (int k = 0; k < 10; k++) tick();

    // Active-low instance: short press, then a long press with repeats disabled.
    idx_a = -1; idx_b = -1;
    for (int k = 0; k < 20; k++) begin
      btn_lo = (k >= 10);
      tick();
      if (pr1) idx_a = k;
      if (rl1) idx_b = k;
    end
    chk("lo_press_cycle", idx_a, 5);
    chk("lo_release_cycle", idx_b, 15);
    btn_lo = 1'b0;
    cnt = 0;
    for (int k = 0; k < 45; k++) begin
      tick();
      cnt += int'(rp1);
    end
    chk("lo_norepeat", cnt, 0);
    chk("lo_held_state", st1, 1);
    btn_lo = 1'b1;
    for (int k = 0; k < 10; k++) tick();

    // Random runs with occasional resets, checked against the model every cycle.
    idx_a = 0; idx_b = 0;
    for (int k = 0; k < 3000; k++) begin
      if (idx_a == 0) begin
        btn = 1'($urandom_range(0, 1));
        idx_a = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 40 : 8);
      end
      if (idx_b == 0) begin
        btn_lo = 1'($urandom_range(0, 1));
        idx_b = $urandom_range(1, 30);
      end
      idx_a--; idx_b--;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for the break-away PMOD button/counter logic. Conditions one raw asynchronous push-button into a debounced level plus single-cycle pulses.
- Pulses: press, release, and auto-repeat while held. All outputs are synchronous to i_clock.
- The downstream counter consumes o_event as a clock enable instead of clocking on posedge of a button-derived signal.
- One instance per button.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (>=2).
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a level change (10 ms at 12 MHz; >=1).
- ACTIVE_HIGH, 1, 1: pressed = input high; 0: pressed = input low.
- REPEAT_ENABLE, 1, 1: generate auto-repeat pulses; 0: o_repeat held 0.
- REPEAT_DELAY_CYCLES, 6000000, cycles from o_press to first o_repeat (500 ms; >=1).
- REPEAT_RATE_CYCLES, 1200000, cycles between subsequent o_repeat pulses (100 ms; >=1).

Ports:
- i_clock  input  1  system clock (12 MHz)
- i_reset_n  input  1  asynchronous active-low reset
- i_button  input  1  raw button pin, asynchronous, may bounce
- o_state  output  1  debounced pressed level (1 = pressed)
- o_press  output  1  one-cycle pulse on accepted press
- o_release  output  1  one-cycle pulse on accepted release
- o_repeat  output  1  one-cycle auto-repeat pulse while held
- o_event  output  1  o_press | o_repeat (registered, same cycle as sources)

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - While i_reset_n = 0: all outputs 0, synchronizer flops at the not-pressed level, all counters 0, FSM in RELEASED.
- Synchronizer: SYNC_STAGES flops. Output is normalized by ACTIVE_HIGH so that 1 means pressed.
- Debounce:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - The counter increments each cycle that the synced level differs from o_state, and clears to 0 on any cycle they match.
  - When the counter reaches DEBOUNCE_CYCLES, o_state takes the synced level and the counter clears.
  - Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles from the first i_clock edge sampling a stable new level to o_state changing.
  - Any disagreement shorter than DEBOUNCE_CYCLES produces no output change.
- o_press and o_release are registered and assert in the same cycle o_state changes, for exactly one cycle.
- Repeat FSM:
  - States: RELEASED, HELD_DELAY, HELD_REPEAT. Timer width is $clog2(max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)+1).
  - RELEASED -> HELD_DELAY on accepted press; timer cleared.
  - HELD_DELAY: timer counts up. At REPEAT_DELAY_CYCLES, o_repeat pulses, the timer clears, and the FSM moves to HELD_REPEAT. The first repeat comes exactly REPEAT_DELAY_CYCLES cycles after o_press.
  - HELD_REPEAT: o_repeat pulses every REPEAT_RATE_CYCLES cycles.
  - Any state -> RELEASED on accepted release; timer cleared.
  - o_repeat is never asserted in the same cycle as o_release.
  - REPEAT_ENABLE = 0: the FSM stays in HELD_DELAY while pressed with the timer frozen, and o_repeat stays 0.
- Boundaries:
  - Button held across reset deassertion: treated as a fresh press, giving o_press after the full latency.
  - Reset asserted mid-pulse: the pulse is truncated immediately.
  - No pulse is generated by reset itself.
  - Timer never wraps: it is cleared on every repeat and every release.

Decomposition:
- Shared package break_away_pkg:
  - FSM state enum (RELEASED, HELD_DELAY, HELD_REPEAT).
  - 12 MHz default timing constants (DEBOUNCE_10MS, REPEAT_DELAY_500MS, REPEAT_RATE_100MS).
- One sub-module: input_synchronizer.
  - Parameters: SYNC_STAGES, RESET_LEVEL.
  - Ports: i_clock, i_reset_n, i_async, o_sync.
  - Reused by other PMOD inputs.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3, ACTIVE_HIGH=1 unless stated.
1. Reset, i_button=1 throughout, release reset at cycle 0 -> all outputs 0 during reset; o_press=o_state rise at cycle 6; no other pulses before cycle 16.
2. Glitch: i_button high for 3 cycles then low -> o_state stays 0; o_press, o_release, o_repeat never assert.
3. Clean press held 30 cycles after o_press at cycle P -> o_repeat and o_event at P+10, P+13, P+16 ... P+28; o_event also at P; o_release only after the release debounce.
4. Bouncy release: i_button toggles every 2 cycles for 10 cycles then stable 0 -> exactly one o_release, 6 cycles after stable 0 is first sampled; no o_repeat in that cycle or after.
5. i_reset_n pulled low mid HELD_REPEAT during an o_repeat cycle -> all outputs 0 in the same cycle (async); after deassert with button held, o_press 6 cycles later and repeats restart from REPEAT_DELAY.
6. ACTIVE_HIGH=0, i_button idle high, driven low for 10 cycles, then high -> o_press at 6 cycles after the low is first sampled; o_release 6 cycles after the high is first sampled; with REPEAT_ENABLE=0 held press of 40 cycles yields no o_repeat.
